gray_code_conv: RTL and testbench

Parametrised, handshaked Gray/binary code converter. Converts a WIDTH-bit word Gray→binary or binary→Gray, selected per beat, behind a single registered valid/ready pipeline stage. In Gray→binary mode it also checks that successive Gray inputs change by at most one bit. It sits between clock-domain-crossing pointer/counter paths and the binary arithmetic that consumes them. It replaces fixed 4-bit, unhandshaked conversion.

---
 rtl/gray_conv_pkg.sv | 25 ++
 rtl/gray_code_conv_if.sv | 30 +++
 rtl/gray_step_chk.sv | 52 +++++
 rtl/gray_code_conv.sv | 68 ++++++
 tb/tb_gray_code_conv.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_conv_pkg.sv
// Shared types and Gray/binary conversion functions for gray_code_conv.
// Functions work on a max-width word; callers zero-extend and truncate to their WIDTH.
package gray_conv_pkg;

  typedef enum logic {GC_G2B = 1'b0, GC_B2G = 1'b1} gc_mode_e;

  localparam int GC_MAX_W = 64;
  typedef logic [GC_MAX_W-1:0] gc_word_t;

  // Zero-padded upper bits contribute nothing to the prefix XOR, so one
  // max-width implementation serves every WIDTH up to GC_MAX_W.
  function automatic gc_word_t gray2bin_f(input gc_word_t g);
    gc_word_t b;
    b[GC_MAX_W-1] = g[GC_MAX_W-1];
    for (int i = GC_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic gc_word_t bin2gray_f(input gc_word_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_code_conv_if.sv
// Handshake bus for gray_code_conv: input beat, output beat and step-error flags.
// master drives beats and accepts results; slave is the converter.
interface gray_code_conv_if
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  gc_mode_e         in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_step_err;
  logic             err_sticky;
  logic             err_clr;

  modport master (
    output in_valid, in_data, in_mode, out_ready, err_clr,
    input  in_ready, out_valid, out_data, out_step_err, err_sticky
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready, err_clr,
    output in_ready, out_valid, out_data, out_step_err, err_sticky
  );

endinterface

// File: rtl/gray_step_chk.sv
// Single-bit-step checker for successive G2B beats, with latched error flag.
// o_step_err is combinational for the beat being offered; history updates on accept.
module gray_step_chk
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_acc,
  input  gc_mode_e         i_mode,
  input  logic [WIDTH-1:0] i_gray,
  input  logic             i_clr,
  output logic             o_step_err,
  output logic             o_err_sticky
);

  logic [WIDTH-1:0] r_prev_gray;
  logic             r_hist_vld;
  logic             r_err_sticky;
  logic [WIDTH-1:0] w_diff;
  logic             w_multi_bit;

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign w_diff      = i_gray ^ r_prev_gray;
  assign w_multi_bit = (w_diff & (w_diff - WIDTH'(1))) != '0;
  assign o_step_err  = (i_mode == GC_G2B) && r_hist_vld && w_multi_bit;
  assign o_err_sticky = r_err_sticky;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_gray  <= '0;
      r_hist_vld   <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      if (i_acc) begin
        if (i_mode == GC_G2B) begin
          r_prev_gray <= i_gray;
          r_hist_vld  <= 1'b1;
        end else begin
          r_hist_vld  <= 1'b0;
        end
      end
      if (i_acc && o_step_err) begin
        r_err_sticky <= 1'b1;
      end else if (i_clr) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gray_code_conv.sv
// Gray<->binary converter behind one registered valid/ready stage; 1-cycle latency, full rate.
// Stall holds the output beat; GRAY_CONV_STEP_CHECK_EN adds the G2B single-bit-step checker.
module gray_code_conv
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  gray_code_conv_if.slave  bus
);

  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_dat;
  logic             r_out_err;
  logic             w_acc;
  logic             w_step_err;
  logic [WIDTH-1:0] w_conv;

  assign bus.in_ready = !r_out_vld || bus.out_ready;
  assign w_acc        = bus.in_valid && bus.in_ready;

  always_comb begin
    w_conv = WIDTH'(gray2bin_f(gc_word_t'(bus.in_data)));
    if (bus.in_mode == GC_B2G) begin
      w_conv = WIDTH'(bin2gray_f(gc_word_t'(bus.in_data)));
    end
  end

`ifdef GRAY_CONV_STEP_CHECK_EN
  gray_step_chk #(
    .WIDTH (WIDTH)
  ) u_step_chk (
    .clk          (clk),
    .rst          (rst),
    .i_acc        (w_acc),
    .i_mode       (bus.in_mode),
    .i_gray       (bus.in_data),
    .i_clr        (bus.err_clr),
    .o_step_err   (w_step_err),
    .o_err_sticky (bus.err_sticky)
  );
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = bus.err_clr;
  assign w_step_err       = 1'b0;
  assign bus.err_sticky   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_out_err <= 1'b0;
    end else if (w_acc) begin
      r_out_vld <= 1'b1;
      r_out_dat <= w_conv;
      r_out_err <= w_step_err;
    end else if (bus.out_ready) begin
      r_out_vld <= 1'b0;
    end
  end

  assign bus.out_valid    = r_out_vld;
  assign bus.out_data     = r_out_dat;
  assign bus.out_step_err = r_out_err;

endmodule

// File: tb/tb_gray_code_conv.sv
// Scoreboard bench for gray_code_conv: directed scenarios, then random traffic, checked
// against an arithmetic reference model (WIDTH=4 instance plus a WIDTH=8 spot check).
module tb_gray_code_conv;
  import gray_conv_pkg::*;

  localparam int W = 4;
`ifdef GRAY_CONV_STEP_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_code_conv_if #(.WIDTH(W)) bus ();
  gray_code_conv_if #(.WIDTH(8)) bus8 ();

  gray_code_conv #(.WIDTH(W)) dut  (.clk(clk), .rst(rst), .bus(bus));
  gray_code_conv #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: binary value whose Gray code equals g, found by search.
  function automatic int unsigned ref_g2b(input int unsigned g, input int w);
    for (int unsigned b = 0; b < (32'd1 << w); b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int unsigned ref_b2g(input int unsigned b);
    return b ^ (b >> 1);
  endfunction

  function automatic int hamming(input int unsigned a, input int unsigned b, input int w);
    int c = 0;
    for (int i = 0; i < w; i++) begin
      if ((((a ^ b) >> i) & 1) != 0) c++;
    end
    return c;
  endfunction

  typedef struct {
    int unsigned dat;
    bit          err;
  } exp_t;

  exp_t        q[$];
  bit          m_vld    = 1'b0;
  bit          m_hist   = 1'b0;
  bit          m_sticky = 1'b0;
  int unsigned m_prev   = 0;

  // Reference model: evaluates each edge from the inputs the bench is driving.
  initial begin : model
    bit   acc;
    exp_t e;
    forever begin
      @(posedge clk);
      acc = bus.in_valid && (!m_vld || bus.out_ready);
      if (rst) begin
        m_vld = 1'b0; m_hist = 1'b0; m_prev = 0; m_sticky = 1'b0;
        q.delete();
      end else if (acc) begin
        if (bus.in_mode == GC_B2G) begin
          e.dat  = ref_b2g(bus.in_data);
          e.err  = 1'b0;
          m_hist = 1'b0;
        end else begin
          e.dat  = ref_g2b(bus.in_data, W);
          e.err  = CHK_EN && m_hist && (hamming(bus.in_data, m_prev, W) > 1);
          m_prev = bus.in_data;
          m_hist = 1'b1;
        end
        q.push_back(e);
        m_vld = 1'b1;
        if (e.err) m_sticky = 1'b1;
        else if (bus.err_clr) m_sticky = 1'b0;
      end else begin
        if (bus.out_ready) m_vld = 1'b0;
        if (bus.err_clr) m_sticky = 1'b0;
      end
    end
  end

  // Monitor: compares presented beats against the scoreboard head.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("out_valid", bus.out_valid, m_vld);
        check("in_ready", bus.in_ready, !m_vld || bus.out_ready);
        check("err_sticky", bus.err_sticky, m_sticky);
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            check("out_data", bus.out_data, q[0].dat);
            check("out_step_err", bus.out_step_err, q[0].err);
            if (bus.out_ready) void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] d, input gc_mode_e m);
    bit rdy;
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      step();
      done = rdy;
    end
    if (!done) check("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] d8;
    logic [W-1:0] last = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = GC_G2B;
    bus.out_ready = 1'b1; bus.err_clr = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_mode = GC_G2B;
    bus8.out_ready = 1'b1; bus8.err_clr = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_step_err", bus.out_step_err, 0);
    check("rst_sticky", bus.err_sticky, 0);
    check("rst_in_ready", bus.in_ready, 1);
    step();

    send(4'b1101, GC_G2B);
    @(negedge clk); check("g2b_1101", bus.out_data, 4'b1001); step();
    send(4'b1001, GC_B2G);
    @(negedge clk); check("b2g_1001", bus.out_data, 4'b1101); step();

    send(4'b0000, GC_G2B); @(negedge clk); check("seq0_err", bus.out_step_err, 0); step();
    send(4'b0001, GC_G2B); @(negedge clk); check("seq1_err", bus.out_step_err, 0); step();
    send(4'b0011, GC_G2B); @(negedge clk); check("seq2_err", bus.out_step_err, 0); step();
    send(4'b0000, GC_G2B); @(negedge clk);
    check("seq3_err", bus.out_step_err, CHK_EN);
    check("seq3_sticky", bus.err_sticky, CHK_EN);
    step();
    bus.err_clr = 1'b1; step(); bus.err_clr = 1'b0;
    @(negedge clk); check("clr_sticky", bus.err_sticky, 0); step();
    bus.err_clr = 1'b1;
    send(4'b0011, GC_G2B);
    bus.err_clr = 1'b0;
    @(negedge clk); check("set_beats_clr", bus.err_sticky, CHK_EN); step();
    bus.err_clr = 1'b1; step(); bus.err_clr = 1'b0;

    // Back-pressure: first beat held, second refused until out_ready returns.
    bus.out_ready = 1'b0;
    send(4'b0001, GC_G2B);
    bus.in_valid = 1'b1; bus.in_data = 4'b0011; bus.in_mode = GC_G2B;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_hold_data", bus.out_data, 4'b0001);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk); check("bp_second", bus.out_data, 4'b0010); step();

    // Mode switch clears history.
    send(4'b0000, GC_G2B);
    bus.err_clr = 1'b1; step(); bus.err_clr = 1'b0;
    send(4'b0101, GC_B2G);
    send(4'b1111, GC_G2B);
    @(negedge clk); check("mode_switch_err", bus.out_step_err, 0); step();

    // Reset while holding a beat with the sticky flag set.
    bus.out_ready = 1'b0;
    send(4'b0000, GC_G2B);
    @(negedge clk); check("pre_rst_sticky", bus.err_sticky, CHK_EN); step();
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_data", bus.out_data, 0);
    check("mid_rst_sticky", bus.err_sticky, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    step();
    bus.out_ready = 1'b1;
    send(4'b1111, GC_G2B);
    @(negedge clk); check("post_rst_unchecked", bus.out_step_err, 0); step();

    // WIDTH=8 instance: directed then random spot checks.
    bus8.in_valid = 1'b1; bus8.in_data = 8'hFF; bus8.in_mode = GC_G2B;
    step(); bus8.in_valid = 1'b0;
    @(negedge clk); check("w8_g2b_ff", bus8.out_data, 8'hAA); step();
    for (int k = 0; k < 20; k++) begin
      d8 = 8'($urandom);
      bus8.in_valid = 1'b1; bus8.in_data = d8;
      bus8.in_mode = ($urandom % 2 == 0) ? GC_G2B : GC_B2G;
      step(); bus8.in_valid = 1'b0;
      @(negedge clk);
      check("w8_rand", bus8.out_data,
            (bus8.in_mode == GC_B2G) ? ref_b2g(d8) : ref_g2b(d8, 8));
      step();
    end

    // Random traffic on the WIDTH=4 instance.
    for (int k = 0; k < 2000; k++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_mode   = ($urandom % 5 == 0) ? GC_B2G : GC_G2B;
      if ($urandom % 2 == 0) bus.in_data = last ^ W'(1 << ($urandom % W));
      else                   bus.in_data = W'($urandom);
      last          = bus.in_data;
      bus.out_ready = ($urandom % 3) != 0;
      bus.err_clr   = ($urandom % 10) == 0;
      rst           = ($urandom % 250) == 0;
      step();
    end
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.err_clr = 1'b0;
    repeat (4) step();
    check("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
